// File: rtl/multi_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : multi_debouncer
// Description : Multi-channel switch/button debouncer. Each channel has its
//               own synchroniser and a restart-on-bounce stability counter.
//               A new level is accepted only after STABLE_CYCLES consecutive
//               cycles in which the synchronised input differs from the
//               current clean level. On acceptance, a one-cycle rise or fall
//               strobe is raised.
//
// Ports       : clk        - system clock, rising edge
//               reset      - synchronous, active-high reset
//               noisy      - raw asynchronous inputs, bit i = channel i
//               debounced  - registered clean level per channel
//               rise       - registered one-cycle strobe, debounced 0->1
//               fall       - registered one-cycle strobe, debounced 1->0
//               any_change - registered OR of all rise and fall bits
//
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
module multi_debouncer #(
    parameter int   CHANNELS      = 4,
    parameter int   STABLE_CYCLES = 1_000_000,
    parameter int   SYNC_STAGES   = 2,
    parameter logic RESET_VALUE   = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] noisy,
    output logic [CHANNELS-1:0] debounced,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                any_change
);

    localparam int CNT_WIDTH = $clog2(STABLE_CYCLES + 1);

    localparam logic [CNT_WIDTH-1:0] c_cnt_last = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_zero = '0;
    localparam logic [CNT_WIDTH-1:0] c_cnt_one  = CNT_WIDTH'(1);

    logic [CHANNELS-1:0] w_s;          // last synchroniser stage per channel
    logic [CHANNELS-1:0] w_accept;     // new level accepted on this edge
    logic [CHANNELS-1:0] r_debounced;
    logic [CHANNELS-1:0] r_rise;
    logic [CHANNELS-1:0] r_fall;
    logic                r_any_change;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [SYNC_STAGES-1:0] r_sync;
            logic [CNT_WIDTH-1:0]   r_cnt;
            logic                   w_mismatch;

            assign w_s[gi]      = r_sync[SYNC_STAGES-1];
            assign w_mismatch   = w_s[gi] ^ r_debounced[gi];
            // The counter only ever reaches c_cnt_last while a mismatch run is
            // in progress, so this compare marks the STABLE_CYCLES-th cycle.
            assign w_accept[gi] = w_mismatch && (r_cnt == c_cnt_last);

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sync <= {SYNC_STAGES{RESET_VALUE}};
                    r_cnt  <= c_cnt_zero;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], noisy[gi]};
                    // Any agreement restarts the count; nothing accumulates
                    // across bounces, and acceptance also clears it.
                    if (!w_mismatch || w_accept[gi]) begin
                        r_cnt <= c_cnt_zero;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_debounced  <= {CHANNELS{RESET_VALUE}};
            r_rise       <= '0;
            r_fall       <= '0;
            r_any_change <= 1'b0;
        end else begin
            r_debounced  <= (r_debounced & ~w_accept) | (w_s & w_accept);
            r_rise       <= w_accept & w_s;
            r_fall       <= w_accept & ~w_s;
            r_any_change <= |w_accept;
        end
    end

    assign debounced  = r_debounced;
    assign rise       = r_rise;
    assign fall       = r_fall;
    assign any_change = r_any_change;

endmodule
`default_nettype wire

// File: tb/tb_multi_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_debouncer
// Description : Self-checking bench for multi_debouncer. A driver applies
//               directed and random stimulus on the falling edge and pushes
//               the expected post-edge outputs into a queue; a monitor pops
//               and compares just after each rising edge.
//               The reference model keeps, per channel, the recent history
//               of sampled inputs. The synchroniser is a pure delay of
//               SYNC_STAGES samples, and a new level is accepted when the
//               last STABLE_CYCLES synchronised values all differ from the
//               current clean level.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_debouncer;

    localparam int   CH     = 4;
    localparam int   STABLE = 4;
    localparam int   SYNC   = 2;
    localparam logic RV     = 1'b0;
    localparam int   HL     = SYNC + STABLE;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic [CH-1:0] noisy = '0;
    logic [CH-1:0] debounced;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic          any_change;

    multi_debouncer #(
        .CHANNELS      (CH),
        .STABLE_CYCLES (STABLE),
        .SYNC_STAGES   (SYNC),
        .RESET_VALUE   (RV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .noisy      (noisy),
        .debounced  (debounced),
        .rise       (rise),
        .fall       (fall),
        .any_change (any_change)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH-1:0] deb;
        logic [CH-1:0] rse;
        logic [CH-1:0] fal;
        logic          any;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state: sampled-input history (index HL-1 = newest)
    logic          m_hist [CH][HL];
    logic [CH-1:0] m_deb;

    // Apply one cycle of stimulus and predict the outputs after that edge.
    task automatic step(input logic rst, input logic [CH-1:0] nz);
        exp_t e;
        logic all_diff;
        @(negedge clk);
        reset = rst;
        noisy = nz;
        e = '0;
        for (int c = 0; c < CH; c++) begin
            if (rst) begin
                for (int j = 0; j < HL; j++) m_hist[c][j] = RV;
                m_deb[c] = RV;
            end else begin
                for (int j = 0; j < HL - 1; j++) m_hist[c][j] = m_hist[c][j+1];
                m_hist[c][HL-1] = nz[c];
                all_diff = 1'b1;
                for (int j = 0; j < STABLE; j++) begin
                    if (m_hist[c][HL-1-SYNC-j] == m_deb[c]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_deb[c] = ~m_deb[c];
                    e.rse[c] = m_deb[c];
                    e.fal[c] = ~m_deb[c];
                end
            end
        end
        e.deb = m_deb;
        e.any = |(e.rse | e.fal);
        exp_q.push_back(e);
    endtask

    // Monitor
    initial begin
        exp_t got_e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                got_e = exp_q.pop_front();
                n_vec++;
                if ({debounced, rise, fall, any_change} !== got_e) begin
                    n_err++;
                    $display("FAIL outputs t=%0t: got deb=%b rise=%b fall=%b any=%b, expected deb=%b rise=%b fall=%b any=%b",
                             $time, debounced, rise, fall, any_change,
                             got_e.deb, got_e.rse, got_e.fal, got_e.any);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d pending", exp_q.size());
        $fatal(1);
    end

    // Stimulus
    initial begin
        logic [CH-1:0] cur;
        int            hold [CH];
        int            w;

        // Reset / idle with inputs already high on channels 1 and 3
        repeat (3)  step(1'b1, 4'b1010);
        repeat (10) step(1'b0, 4'b1010);
        // Release both, then clean press on channel 0
        repeat (8)  step(1'b0, 4'b0000);
        repeat (10) step(1'b0, 4'b0001);
        // Return low, then bounce rejection on channel 0
        repeat (8)  step(1'b0, 4'b0000);
        repeat (3)  step(1'b0, 4'b0001);
        step(1'b0, 4'b0000);
        repeat (3)  step(1'b0, 4'b0001);
        repeat (8)  step(1'b0, 4'b0000);
        // Simultaneous rise on ch1 / fall on ch2 from debounced = 0100
        repeat (8)  step(1'b0, 4'b0100);
        repeat (8)  step(1'b0, 4'b0010);
        // Reset mid-count on channel 3
        repeat (4)  step(1'b0, 4'b1000);
        repeat (2)  step(1'b1, 4'b1000);
        repeat (8)  step(1'b0, 4'b1000);
        // Release edge on channel 2, then a one-cycle glitch
        repeat (8)  step(1'b0, 4'b0100);
        repeat (8)  step(1'b0, 4'b0000);
        step(1'b0, 4'b0100);
        repeat (6)  step(1'b0, 4'b0000);

        // Random bouncy traffic with mixed short and long hold times
        cur = '0;
        for (int c = 0; c < CH; c++) hold[c] = int'($urandom_range(1, 8));
        for (int k = 0; k < 2000; k++) begin
            for (int c = 0; c < CH; c++) begin
                if (hold[c] == 0) begin
                    cur[c] = ~cur[c];
                    if ($urandom_range(0, 3) == 0)
                        hold[c] = int'($urandom_range(5, 12));
                    else
                        hold[c] = int'($urandom_range(0, 4));
                end else begin
                    hold[c]--;
                end
            end
            step($urandom_range(0, 199) == 0, cur);
        end

        // Drain outstanding expectations within a bounded number of cycles
        w = 0;
        while (exp_q.size() > 0 && w < 10) begin
            @(posedge clk);
            #2;
            w++;
        end
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations pending, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
